// File: rtl/r200_pkg.sv
// rtl/r200_pkg.sv - shared width default, FSM state type and func3 codes for the LSU
package r200_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic f3_load_ok(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic f3_store_ok(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/r200_ldext.sv
// rtl/r200_ldext.sv - load lane shift and sign/zero extension (combinational)
module r200_ldext
    import r200_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      a,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {a, 3'b000};
        data    = rdata;
        case (func3)
            F3_LB:   data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/r200_lsu.sv
// rtl/r200_lsu.sv - load/store unit between EX and writeback; R200_MISALIGN_TRAP_EN enables misalignment trap
module r200_lsu
    import r200_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [2:0]      in_func3,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [XLEN-1:0] in_store_data,
    input  logic            flush,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_err
);

    lsu_state_t      state, state_d;
    logic [XLEN-1:0] addr_q, wdata_q, wb_data_q, ext_data;
    logic [3:0]      be_q, be_new;
    logic [2:0]      f3_q;
    logic [1:0]      lane_q, lane_eff;
    logic [4:0]      rd_q;
    logic            load_q, we_q, wb_we_q;
    logic            ld_op, st_op, mem_op, trap, accept, ld_capture;
    logic [XLEN-1:0] wdata_new;
    lsu_state_t      op_next;

    // Malformed func3 on a load/store class degrades to an ALU pass-through.
    assign ld_op  = in_is_load && f3_load_ok(in_func3);
    assign st_op  = !in_is_load && in_is_store && f3_store_ok(in_func3);
    assign mem_op = ld_op || st_op;

    always_comb begin
        lane_eff  = 2'b00;
        be_new    = 4'b1111;
        wdata_new = in_store_data;
        case (in_func3[1:0])
            2'b00: begin
                lane_eff  = in_alu_res[1:0];
                wdata_new = XLEN'({4{in_store_data[7:0]}});
                if (st_op) be_new = 4'b0001 << lane_eff;
            end
            2'b01: begin
                lane_eff  = {in_alu_res[1], 1'b0};
                wdata_new = XLEN'({2{in_store_data[15:0]}});
                if (st_op) be_new = 4'b0011 << lane_eff;
            end
            default: lane_eff = 2'b00;
        endcase
    end

`ifdef R200_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap = mem_op && (((in_func3[1:0] == 2'b01) && in_alu_res[0]) ||
                             ((in_func3[1:0] == 2'b10) && (in_alu_res[1:0] != 2'b00)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= accept && trap;
    end
    assign misalign_err = misalign_q;
`else
    assign trap         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign op_next  = (mem_op && !trap) ? REQ : DONE;
    assign in_ready = (state == IDLE) || ((state == DONE) && wb_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_d    = state;
        ld_capture = 1'b0;
        case (state)
            IDLE:  if (accept) state_d = op_next;
            REQ: begin
                if (flush)         state_d = (dmem_gnt && load_q) ? DRAIN : IDLE;
                else if (dmem_gnt) state_d = load_q ? WAIT : DONE;
            end
            WAIT: begin
                // A response arriving with the flush is already drained.
                if (flush)            state_d = dmem_rvalid ? IDLE : DRAIN;
                else if (dmem_rvalid) begin
                    state_d    = DONE;
                    ld_capture = 1'b1;
                end
            end
            DONE: begin
                if (flush)         state_d = IDLE;
                else if (wb_ready) state_d = accept ? op_next : IDLE;
            end
            DRAIN: if (dmem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= 4'b0000;
            lane_q    <= 2'b00;
            f3_q      <= 3'b000;
            load_q    <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= 5'd0;
            wb_we_q   <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                addr_q    <= {in_alu_res[XLEN-1:2], 2'b00};
                wdata_q   <= wdata_new;
                be_q      <= be_new;
                lane_q    <= lane_eff;
                f3_q      <= in_func3;
                load_q    <= ld_op;
                we_q      <= st_op;
                rd_q      <= in_rd;
                wb_we_q   <= !mem_op && (in_rd != 5'd0);
                wb_data_q <= in_alu_res;
            end else if (ld_capture) begin
                wb_data_q <= ext_data;
                wb_we_q   <= (rd_q != 5'd0);
            end
        end
    end

    r200_ldext #(.XLEN(XLEN)) u_ldext (
        .rdata (dmem_rdata),
        .a     (lane_q),
        .func3 (f3_q),
        .data  (ext_data)
    );

    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req && we_q;
    assign dmem_be    = dmem_req ? be_q : 4'b0000;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = (state == DONE);
    assign wb_we      = wb_valid && wb_we_q;
    assign wb_rd      = rd_q;
    assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_r200_lsu.sv
// tb/tb_r200_lsu.sv - directed self-checking bench for r200_lsu
module tb_r200_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic        in_is_load = 1'b0, in_is_store = 1'b0;
    logic [2:0]  in_func3 = 3'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [31:0] in_alu_res = '0, in_store_data = '0;
    logic        flush = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_ready = 1'b1, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;

    int nt = 0;
    int nf = 0;

    always #5 clk = ~clk;

    r200_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_func3(in_func3), .in_rd(in_rd),
        .in_alu_res(in_alu_res), .in_store_data(in_store_data),
        .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err)
    );

    // Presents one op for a single cycle; returns at the following negedge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_func3 = f3;
        in_rd = rd; in_alu_res = a; in_store_data = d;
        @(negedge clk);
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    endtask

    task automatic grant();
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        dmem_rvalid = 1'b1; dmem_rdata = d;
        @(negedge clk);
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        nt++; if (in_ready !== 1'b1) begin nf++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        nt++; if ({dmem_req, dmem_we, dmem_be, wb_valid, wb_we, misalign_err} !== 9'b0) begin
            nf++; $display("FAIL reset_ctrl got %b exp 0", {dmem_req, dmem_we, dmem_be, wb_valid, wb_we, misalign_err}); end
        nt++; if ({wb_data, wb_rd, dmem_addr} !== 69'b0) begin
            nf++; $display("FAIL reset_data got %h/%h/%h exp 0", wb_data, wb_rd, dmem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu();
        issue(1'b0, 1'b0, 3'b000, 5'd5, 32'h1234, 32'h0);
        nt++; if ({wb_valid, wb_we, wb_rd} !== {1'b1, 1'b1, 5'd5}) begin
            nf++; $display("FAIL alu_ctrl got v%b we%b rd%0d exp v1 we1 rd5", wb_valid, wb_we, wb_rd); end
        nt++; if (wb_data !== 32'h1234) begin nf++; $display("FAIL alu_data got %h exp 00001234", wb_data); end
        @(negedge clk);
        nt++; if (wb_valid !== 1'b0) begin nf++; $display("FAIL alu_release got %b exp 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3] = '{32'hA, 32'hB0B0, 32'hFFFF_0001};
        logic [4:0]  rds  [3] = '{5'd1, 5'd0, 5'd31};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_func3 = 3'b000; in_rd = rds[i]; in_alu_res = vals[i];
            @(negedge clk);
            nt++; if ({wb_valid, wb_data, wb_we} !== {1'b1, vals[i], rds[i] != 5'd0}) begin
                nf++; $display("FAIL b2b_%0d got v%b %h we%b exp v1 %h we%b", i, wb_valid, wb_data, wb_we, vals[i], rds[i] != 5'd0); end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        issue(1'b0, 1'b1, 3'b000, 5'd7, 32'h103, 32'hAB);
        for (int i = 0; i < 3; i++) begin
            nt++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h100, 4'b1000, 32'hABABABAB}) begin
                nf++; $display("FAIL sb_req_%0d got r%b w%b %h %b %h exp r1 w1 00000100 1000 abababab",
                               i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata); end
            if (i < 2) @(negedge clk);
        end
        grant();
        nt++; if ({wb_valid, wb_we, dmem_req} !== 3'b100) begin
            nf++; $display("FAIL sb_done got v%b we%b req%b exp v1 we0 req0", wb_valid, wb_we, dmem_req); end
        @(negedge clk);
        issue(1'b0, 1'b1, 3'b001, 5'd7, 32'h202, 32'h1234ABCD);
        nt++; if ({dmem_addr, dmem_be, dmem_wdata} !== {32'h200, 4'b1100, 32'hABCDABCD}) begin
            nf++; $display("FAIL sh_req got %h %b %h exp 00000200 1100 abcdabcd", dmem_addr, dmem_be, dmem_wdata); end
        grant();
        @(negedge clk);
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] as  [4] = '{32'h101, 32'h101, 32'h102, 32'h102};
        logic [31:0] rds [4] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000, 32'h8001_0000};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, f3s[i], 5'd3, as[i], 32'h0);
            nt++; if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h100}) begin
                nf++; $display("FAIL ld_req_%0d got r%b w%b %b %h exp r1 w0 1111 00000100", i, dmem_req, dmem_we, dmem_be, dmem_addr); end
            grant();
            respond(rds[i]);
            nt++; if ({wb_valid, wb_we, wb_data} !== {1'b1, 1'b1, exp[i]}) begin
                nf++; $display("FAIL ld_ext_%0d got v%b we%b %h exp v1 we1 %h", i, wb_valid, wb_we, wb_data, exp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_stall();
        wb_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 5'd9, 32'h200, 32'h0);
        grant();
        respond(32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            nt++; if ({wb_valid, wb_we, wb_rd, wb_data, in_ready} !== {1'b1, 1'b1, 5'd9, 32'hDEADBEEF, 1'b0}) begin
                nf++; $display("FAIL lw_stall_%0d got v%b we%b rd%0d %h rdy%b exp v1 we1 rd9 deadbeef rdy0",
                               i, wb_valid, wb_we, wb_rd, wb_data, in_ready); end
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1;
        nt++; if (in_ready !== 1'b1) begin nf++; $display("FAIL lw_release_ready got %b exp 1", in_ready); end
        @(negedge clk);
        nt++; if (wb_valid !== 1'b0) begin nf++; $display("FAIL lw_release_valid got %b exp 0", wb_valid); end
    endtask

    task automatic test_flush();
        issue(1'b1, 1'b0, 3'b010, 5'd4, 32'h300, 32'h0);
        grant();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        nt++; if ({wb_valid, in_ready} !== 2'b00) begin
            nf++; $display("FAIL flush_drain got v%b rdy%b exp v0 rdy0", wb_valid, in_ready); end
        @(negedge clk);
        nt++; if (in_ready !== 1'b0) begin nf++; $display("FAIL flush_drain_hold got %b exp 0", in_ready); end
        respond(32'h5555_5555);
        nt++; if ({wb_valid, in_ready} !== 2'b01) begin
            nf++; $display("FAIL flush_idle got v%b rdy%b exp v0 rdy1", wb_valid, in_ready); end
        issue(1'b0, 1'b1, 3'b010, 5'd0, 32'h400, 32'h1);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        nt++; if ({dmem_req, wb_valid, in_ready} !== 3'b001) begin
            nf++; $display("FAIL flush_req got req%b v%b rdy%b exp req0 v0 rdy1", dmem_req, wb_valid, in_ready); end
    endtask

    task automatic test_misalign();
        issue(1'b1, 1'b0, 3'b010, 5'd6, 32'h102, 32'h0);
`ifdef R200_MISALIGN_TRAP_EN
        nt++; if ({misalign_err, dmem_req, wb_valid, wb_we} !== 4'b1010) begin
            nf++; $display("FAIL trap_pulse got err%b req%b v%b we%b exp 1 0 1 0", misalign_err, dmem_req, wb_valid, wb_we); end
        @(negedge clk);
        nt++; if ({misalign_err, dmem_req} !== 2'b00) begin
            nf++; $display("FAIL trap_after got err%b req%b exp 0 0", misalign_err, dmem_req); end
`else
        nt++; if ({misalign_err, dmem_req, dmem_addr, dmem_be} !== {1'b0, 1'b1, 32'h100, 4'b1111}) begin
            nf++; $display("FAIL align_force got err%b req%b %h %b exp 0 1 00000100 1111", misalign_err, dmem_req, dmem_addr, dmem_be); end
        grant();
        respond(32'h1122_3344);
        nt++; if (wb_data !== 32'h1122_3344) begin nf++; $display("FAIL align_data got %h exp 11223344", wb_data); end
        @(negedge clk);
`endif
    endtask

    task automatic test_invalid_func3();
        issue(1'b1, 1'b0, 3'b011, 5'd2, 32'h0000_0ABC, 32'h0);
        nt++; if ({dmem_req, wb_valid, wb_we, wb_data} !== {1'b0, 1'b1, 1'b1, 32'hABC}) begin
            nf++; $display("FAIL bad_f3 got req%b v%b we%b %h exp 0 1 1 00000abc", dmem_req, wb_valid, wb_we, wb_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        issue(1'b1, 1'b0, 3'b010, 5'd8, 32'h500, 32'h0);
        grant();
        #2 rst_n = 1'b0;
        #1;
        nt++; if ({in_ready, wb_valid, dmem_req, wb_data, dmem_addr} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            nf++; $display("FAIL rst_wait got rdy%b v%b req%b %h %h exp 1 0 0 0 0", in_ready, wb_valid, dmem_req, wb_data, dmem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        respond(32'hCAFE_F00D);
        nt++; if ({wb_valid, in_ready} !== 2'b01) begin
            nf++; $display("FAIL rst_stray got v%b rdy%b exp v0 rdy1", wb_valid, in_ready); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_store();
        test_load_ext();
        test_lw_stall();
        test_flush();
        test_misalign();
        test_invalid_func3();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule

// File: doc/r200_lsu.md
R200_LSU -- requirements
Module: r200_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/address width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-003 SHALL have port in_valid  in  1  EX result valid.
REQ-004 SHALL have port in_ready  out  1  LSU can accept an op.
REQ-005 SHALL have ports in_is_load, in_is_store  in  1 each  op class (both 0 = ALU pass-through).
REQ-006 SHALL have ports in_func3  in  3  instr[14:12]; in_rd  in  5  destination reg.
REQ-007 SHALL have ports in_alu_res  in  XLEN  ALU result/address; in_store_data  in  XLEN  rs2 value.
REQ-008 SHALL have port flush  in  1  kill current and in-flight op.
REQ-009 SHALL have ports dmem_req, dmem_we  out  1; dmem_addr  out  XLEN  word-aligned; dmem_wdata  out  XLEN; dmem_be  out  4.
REQ-010 SHALL have ports dmem_gnt  in  1; dmem_rvalid  in  1; dmem_rdata  in  XLEN.
REQ-011 SHALL have ports wb_valid  out  1; wb_ready  in  1; wb_we  out  1; wb_rd  out  5; wb_data  out  XLEN.
REQ-012 SHALL have port misalign_err  out  1  pulse on misaligned access.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, DONE, DRAIN.
REQ-014 SHALL assert in_ready in IDLE, and in DONE when wb_ready=1; an op is accepted when in_valid&in_ready.
REQ-015 SHALL, on an ALU op, go to DONE next cycle with wb_data=in_alu_res, wb_we=(in_rd!=0); latency 1.
REQ-016 SHALL, on a load/store, go to REQ, holding dmem_req=1 and all dmem_* stable until dmem_gnt=1.
REQ-017 SHALL drive dmem_addr={addr[XLEN-1:2],2'b00}.
REQ-018 SHALL set dmem_be for SB/SH/SW to 4'b0001<<a[1:0], 4'b0011<<{a[1],1'b0}, 4'b1111, with wdata replicated across lanes; loads SHALL use be=4'b1111.
REQ-019 SHALL move a store to DONE with wb_we=0 on gnt; a load SHALL move to WAIT on gnt.
REQ-020 SHALL, in WAIT, on dmem_rvalid, shift the lane by a[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU/LW) into wb_data, then go to DONE.
REQ-021 SHALL treat rvalid in the same cycle as gnt as not legal; the memory returns rvalid at least 1 cycle after gnt.
REQ-022 SHALL hold wb_valid=1 with stable wb_* in DONE until wb_ready; DONE&wb_ready&in_valid SHALL accept the next op (back-to-back ALU ops at 1/cycle).
REQ-023 SHALL, on flush in REQ (no gnt yet) or DONE, go to IDLE; flush in WAIT, or in REQ coincident with gnt for a load, SHALL go to DRAIN; DRAIN discards the rvalid, then goes to IDLE; in_ready=0 in DRAIN.
REQ-024 SHALL give flush priority over acceptance in the same cycle.
REQ-025 SHALL treat invalid func3 (011, 11x) as ALU pass-through.

Reset
REQ-026 SHALL, on rst_n=0, go to IDLE immediately with in_ready=1, and dmem_req, dmem_we, dmem_be, wb_valid, wb_we, misalign_err, wb_data, wb_rd and dmem_addr all =0.
REQ-027 SHALL, on reset during WAIT, drop any later rvalid (a stray rvalid in IDLE is ignored).

Configuration
REQ-028 SHALL use macro R200_MISALIGN_TRAP_EN; when defined, a halfword with a[0]=1 or a word with a[1:0]!=0 SHALL issue no dmem_req, SHALL pulse misalign_err for 1 cycle, and SHALL go to DONE with wb_we=0.
REQ-029 SHALL, without R200_MISALIGN_TRAP_EN, tie misalign_err to 0, force the low address bits to the natural alignment, and issue the access.

Structure
REQ-030 SHALL place XLEN default, the lsu_state_t enum, and the func3 codes (LB..LHU, SB..SW) in shared package r200_pkg.
REQ-031 SHALL implement lane shift and extension as combinational sub-module r200_ldext (inputs rdata, a[1:0], func3; output XLEN).

Verification
REQ-032 SHALL cover: ALU op alu_res=0x1234, rd=5, wb_ready=1 -> wb_valid next cycle, wb_data=0x1234, wb_we=1.
REQ-033 SHALL cover: SB addr=0x103, data=0xAB, gnt after 2 cycles -> dmem_addr=0x100, be=4'b1000, wdata=0xABABABAB, wb_we=0.
REQ-034 SHALL cover: LB addr=0x101, rdata=0x0000_8000 -> wb_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-035 SHALL cover: LW with wb_ready=0 for 3 cycles -> wb_* stable, in_ready=0 until wb_ready=1.
REQ-036 SHALL cover: flush in WAIT, then rvalid 2 cycles later -> no wb_valid, FSM back in IDLE after rvalid.
REQ-037 SHALL cover: with R200_MISALIGN_TRAP_EN, LW addr=0x102 -> misalign_err 1-cycle pulse, dmem_req never asserted.
